// File: rtl/tsv_link_serdes_if.sv
// Handshake/bus bundle between self_test, the TSV link serdes and the serial TSV pins.
// master: drives tx_req/tx_data/tsv_rx; slave: the serdes, drives status, tsv_tx and rx_* outputs.
interface tsv_link_serdes_if #(
   parameter int DATA_W = 32
);
   logic              tx_req;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_drop;
   logic              tsv_tx;
   logic              tsv_rx;
   logic [DATA_W-1:0] rx_word;
   logic              rx_valid;
   logic              rx_err;
   logic [7:0]        err_cnt;

   modport master (
      output tx_req, tx_data, tsv_rx,
      input  tx_busy, tx_done, tx_drop, tsv_tx,
      input  rx_word, rx_valid, rx_err, err_cnt
   );

   modport slave (
      input  tx_req, tx_data, tsv_rx,
      output tx_busy, tx_done, tx_drop, tsv_tx,
      output rx_word, rx_valid, rx_err, err_cnt
   );
endinterface

// File: rtl/tsv_link_serdes.sv
// Inter-layer TSV link: serialises self_test words onto a 1-bit TSV and deserialises the
// adjacent layer's frames, holding each good word on rx_word for HOLD_CYC cycles.
// Ports: clk, rst (sync, active high), bus (slave modport: tx_req/tx_data in, tx_busy/
// tx_done/tx_drop/tsv_tx out, tsv_rx in, rx_word/rx_valid/rx_err/err_cnt out).
module tsv_link_serdes #(
   parameter int DATA_W   = 32,
   parameter int BIT_DIV  = 4,
   parameter int HOLD_CYC = 4
) (
   input logic               clk,
   input logic               rst,
   tsv_link_serdes_if.slave  bus
);
   localparam int FW  = DATA_W + 3;
   localparam int IW  = $clog2(FW);
   localparam int CW  = $clog2(BIT_DIV);
   localparam int RIW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int HW  = $clog2(HOLD_CYC + 1);

   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   tx_state_t         tx_state;
   logic [CW-1:0]     tx_cnt;
   logic [IW-1:0]     tx_idx;
   logic [DATA_W+1:0] tx_sh;

   rx_state_t         rx_state;
   logic              sync1, sync2;
   logic [CW-1:0]     rx_cnt;
   logic [RIW-1:0]    rx_idx;
   logic [DATA_W-1:0] rx_sh;
   logic              rx_par;
   logic [HW-1:0]     hold_cnt;

   // tx_sh holds the bits after the start bit: data, parity, stop (LSB first).
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         tx_idx      <= '0;
         tx_sh       <= '0;
         bus.tsv_tx  <= 1'b1;
         bus.tx_busy <= 1'b0;
         bus.tx_done <= 1'b0;
         bus.tx_drop <= 1'b0;
      end else begin
         bus.tx_done <= 1'b0;
         bus.tx_drop <= 1'b0;
         unique case (tx_state)
            TX_IDLE: begin
               if (bus.tx_req) begin
                  tx_sh       <= {1'b1, ^bus.tx_data, bus.tx_data};
                  bus.tsv_tx  <= 1'b0;
                  bus.tx_busy <= 1'b1;
                  tx_cnt      <= '0;
                  tx_idx      <= '0;
                  tx_state    <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (bus.tx_req) bus.tx_drop <= 1'b1;
               if (tx_cnt == CW'(BIT_DIV - 1)) begin
                  tx_cnt <= '0;
                  if (tx_idx == IW'(FW - 1)) begin
                     tx_state    <= TX_IDLE;
                     bus.tx_busy <= 1'b0;
                     bus.tx_done <= 1'b1;
                     bus.tsv_tx  <= 1'b1;
                  end else begin
                     tx_idx     <= tx_idx + 1'b1;
                     bus.tsv_tx <= tx_sh[0];
                     tx_sh      <= {1'b1, tx_sh[DATA_W+1:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Hold countdown runs first; a good stop sample below overrides it and restarts.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state     <= RX_IDLE;
         sync1        <= 1'b1;
         sync2        <= 1'b1;
         rx_cnt       <= '0;
         rx_idx       <= '0;
         rx_sh        <= '0;
         rx_par       <= 1'b0;
         hold_cnt     <= '0;
         bus.rx_word  <= '0;
         bus.rx_valid <= 1'b0;
         bus.rx_err   <= 1'b0;
         bus.err_cnt  <= '0;
      end else begin
         sync1      <= bus.tsv_rx;
         sync2      <= sync1;
         bus.rx_err <= 1'b0;
         if (hold_cnt == HW'(1)) begin
            hold_cnt     <= '0;
            bus.rx_word  <= '0;
            bus.rx_valid <= 1'b0;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         unique case (rx_state)
            RX_IDLE: begin
               if (!sync2) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == CW'(BIT_DIV / 2 - 1)) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == CW'(BIT_DIV - 1)) begin
                  rx_cnt <= '0;
                  rx_sh  <= {sync2, rx_sh[DATA_W-1:1]};
                  if (rx_idx == RIW'(DATA_W - 1)) rx_state <= RX_PAR;
                  else rx_idx <= rx_idx + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_PAR: begin
               if (rx_cnt == CW'(BIT_DIV - 1)) begin
                  rx_cnt   <= '0;
                  rx_par   <= sync2;
                  rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == CW'(BIT_DIV - 1)) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
                  if (sync2 && (rx_par == ^rx_sh)) begin
                     bus.rx_word  <= rx_sh;
                     bus.rx_valid <= 1'b1;
                     hold_cnt     <= HW'(HOLD_CYC);
                  end else begin
                     bus.rx_err <= 1'b1;
                     if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tsv_link_serdes.sv
// Self-checking bench for tsv_link_serdes: vector table of injected frames, loopback sends,
// multi-cycle corner sequences and randomized frames checked against a frame-level model.
module tb_tsv_link_serdes;
   localparam int DW = 32;
   localparam int BD = 4;
   localparam int FW = DW + 3;

   logic clk = 1'b0;
   logic rst;
   logic loop;
   logic inj;

   always #5 clk = ~clk;

   tsv_link_serdes_if #(.DATA_W(DW)) ifa ();
   tsv_link_serdes_if #(.DATA_W(DW)) ifb ();

   assign ifa.tsv_rx  = loop ? ifa.tsv_tx : inj;
   assign ifb.tx_req  = ifa.tx_req;
   assign ifb.tx_data = ifa.tx_data;
   assign ifb.tsv_rx  = ifa.tsv_rx;

   tsv_link_serdes #(.DATA_W(DW), .BIT_DIV(BD), .HOLD_CYC(4)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave)
   );

   tsv_link_serdes #(.DATA_W(DW), .BIT_DIV(BD), .HOLD_CYC(200)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave)
   );

   int passed = 0;
   int total  = 0;
   int m_err  = 0;

   int a_err_n   = 0;
   int a_valid_n = 0;
   int a_drop_n  = 0;
   int a_leak_n  = 0;
   logic [DW-1:0] a_last = '0;

   always @(negedge clk) begin
      if (ifa.rx_err)   a_err_n++;
      if (ifa.tx_drop)  a_drop_n++;
      if (ifa.rx_valid) begin
         a_valid_n++;
         a_last = ifa.rx_word;
      end
      if (!ifa.rx_valid && ifa.rx_word != '0) a_leak_n++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [FW-1:0] mkframe(input logic [DW-1:0] d);
      return {1'b1, ^d, d, 1'b0};
   endfunction

   // Receiver accepts a frame iff the parity bit equals the XOR of the data and stop is 1.
   function automatic bit pred_ok(input logic [FW-1:0] f);
      return (f[DW+1] == ^f[DW:1]) && f[DW+2];
   endfunction

   task automatic inject(input logic [FW-1:0] f);
      loop = 1'b0;
      for (int i = 0; i < FW; i++) begin
         inj = f[i];
         step(BD);
      end
      inj = 1'b1;
   endtask

   task automatic rx_check(input string nm, input logic [FW-1:0] f,
                           input bit ok, input logic [DW-1:0] word);
      int e0, v0;
      e0 = a_err_n;
      v0 = a_valid_n;
      inject(f);
      step(16);
      if (!ok && m_err < 255) m_err++;
      chk({nm, " err_pulses"}, a_err_n - e0, ok ? 1'b0 : 1'b1);
      chk({nm, " valid_cycles"}, a_valid_n - v0, ok ? 4 : 0);
      if (ok) chk({nm, " word"}, a_last, word);
      chk({nm, " err_cnt"}, ifa.err_cnt, m_err);
   endtask

   task automatic send(input logic [DW-1:0] d, input int drop_at, output int busy_n);
      int g;
      loop = 1'b1;
      ifa.tx_req  = 1'b1;
      ifa.tx_data = d;
      step(1);
      ifa.tx_req  = 1'b0;
      ifa.tx_data = $urandom;
      busy_n = 0;
      g = 0;
      while (!ifa.tx_done && g < 400) begin
         if (ifa.tx_busy) busy_n++;
         if (g == drop_at) begin
            ifa.tx_req  = 1'b1;
            ifa.tx_data = '0;
         end else begin
            ifa.tx_req = 1'b0;
         end
         step(1);
         g++;
      end
      ifa.tx_req = 1'b0;
      chk("tx_done_seen", g < 400, 1);
   endtask

   task automatic loop_check(input string nm, input logic [DW-1:0] d, input int drop_at);
      int e0, v0, dr0, bn;
      e0  = a_err_n;
      v0  = a_valid_n;
      dr0 = a_drop_n;
      send(d, drop_at, bn);
      step(16);
      chk({nm, " busy_cycles"}, bn, 140);
      chk({nm, " valid_cycles"}, a_valid_n - v0, 4);
      chk({nm, " word"}, a_last, d);
      chk({nm, " err_pulses"}, a_err_n - e0, 0);
      chk({nm, " drops"}, a_drop_n - dr0, (drop_at >= 0) ? 1 : 0);
      chk({nm, " word_cleared"}, ifa.rx_word, 0);
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic [DW-1:0] dmask;
      bit            pflip;
      bit            stop;
      bit            ok;
      logic [DW-1:0] word;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [FW-1:0] f;
      logic [DW-1:0] d;
      int bn, e0, v0, n, gap, g, r1, r2;
      bit seen1;

      tbl[0] = '{32'hA112BEEF, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA112BEEF};
      tbl[1] = '{32'hA112BEEF, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[2] = '{32'h00000000, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0};
      tbl[3] = '{32'hFFFFFFFF, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};
      tbl[4] = '{32'h5A5A5A5A, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0};
      tbl[5] = '{32'h12345678, 32'h11, 1'b0, 1'b1, 1'b1, 32'h12345669};

      rst = 1'b1;
      loop = 1'b1;
      inj = 1'b1;
      ifa.tx_req = 1'b0;
      ifa.tx_data = '0;
      step(3);
      chk("rst tsv_tx", ifa.tsv_tx, 1);
      chk("rst rx_word", ifa.rx_word, 0);
      chk("rst err_cnt", ifa.err_cnt, 0);
      chk("rst tx_busy", ifa.tx_busy, 0);
      chk("rst tx_done", ifa.tx_done, 0);
      chk("rst tx_drop", ifa.tx_drop, 0);
      chk("rst rx_valid", ifa.rx_valid, 0);
      chk("rst rx_err", ifa.rx_err, 0);
      rst = 1'b0;
      step(2);

      for (int i = 0; i < 6; i++) begin
         f = mkframe(tbl[i].d);
         f[DW:1] = f[DW:1] ^ tbl[i].dmask;
         f[DW+1] = f[DW+1] ^ tbl[i].pflip;
         f[DW+2] = tbl[i].stop;
         rx_check($sformatf("vec%0d", i), f, tbl[i].ok, tbl[i].word);
      end

      loop_check("loopback", 32'hA112BEEF, -1);
      loop_check("drop", 32'h600DF00D, 10);

      e0 = a_err_n;
      v0 = a_valid_n;
      loop = 1'b0;
      inj = 1'b0;
      step(1);
      inj = 1'b1;
      step(4);
      chk("glitch err", a_err_n - e0, 0);
      chk("glitch valid", a_valid_n - v0, 0);
      rx_check("after_glitch", mkframe(32'hC0FFEE01), 1'b1, 32'hC0FFEE01);

      loop = 1'b1;
      ifa.tx_req = 1'b1;
      ifa.tx_data = 32'hDEADBEEF;
      step(1);
      ifa.tx_req = 1'b0;
      step(12 * BD);
      rst = 1'b1;
      step(1);
      chk("midframe_rst tsv_tx", ifa.tsv_tx, 1);
      chk("midframe_rst tx_busy", ifa.tx_busy, 0);
      rst = 1'b0;
      m_err = 0;
      chk("midframe_rst err_cnt", ifa.err_cnt, 0);
      step(2);
      loop_check("post_reset", 32'h0BADCAFE, -1);

      send(32'h1111BEEF, -1, bn);
      loop = 1'b1;
      ifa.tx_req = 1'b1;
      ifa.tx_data = 32'h2222BEEF;
      seen1 = 1'b0;
      gap = 0;
      g = 0;
      while (ifb.rx_word != 32'h2222BEEF && g < 400) begin
         step(1);
         ifa.tx_req = 1'b0;
         if (ifb.rx_word == 32'h1111BEEF) seen1 = 1'b1;
         if (seen1 && !ifb.rx_valid) gap++;
         g++;
      end
      chk("b2b first_word", seen1, 1);
      chk("b2b second_word", ifb.rx_word, 32'h2222BEEF);
      chk("b2b valid_gap", gap, 0);
      n = 0;
      while (ifb.rx_valid && n < 300) begin
         n++;
         step(1);
      end
      chk("b2b hold_restart", n, 200);
      chk("b2b cleared", ifb.rx_word, 0);

      for (int k = 0; k < 12; k++) begin
         d  = $urandom;
         f  = mkframe(d);
         r1 = $urandom_range(1, DW);
         r2 = (r1 % DW) + 1;
         case ($urandom_range(0, 4))
            1: f[r1] = ~f[r1];
            2: f[DW+1] = ~f[DW+1];
            3: f[DW+2] = 1'b0;
            4: begin
               f[r1] = ~f[r1];
               f[r2] = ~f[r2];
            end
            default: ;
         endcase
         rx_check($sformatf("rand%0d", k), f, pred_ok(f), f[DW:1]);
      end
      for (int k = 0; k < 3; k++) begin
         d = $urandom;
         loop_check($sformatf("rand_loop%0d", k), d, -1);
      end

      e0 = a_err_n;
      for (int k = 0; k < 256; k++) begin
         f = mkframe($urandom);
         f[DW+2] = 1'b0;
         if (!pred_ok(f) && m_err < 255) m_err++;
         inject(f);
         step(12);
      end
      chk("sat err_pulses", a_err_n - e0, 256);
      chk("sat err_cnt", ifa.err_cnt, m_err);
      chk("sat err_cnt_255", ifa.err_cnt, 8'hFF);
      chk("valid_word_invariant", a_leak_n, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
